// File: rtl/adj_eq_monitor.sv
// Purpose: adjacent-bit equality monitor with OR/AND reduction, saturating hit count and run alarm.
// Latency: 1 cycle from accepted sample to out_valid/f/pair_eq; hit_cnt and alarm update on the same edge.
// Backpressure: none; every in_valid cycle is accepted, out_valid is a single-cycle pulse per sample.
module adj_eq_monitor #(
    parameter int WIDTH   = 4,
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             mode,
    input  logic             clr,
    output logic             out_valid,
    output logic             f,
    output logic [WIDTH-2:0] pair_eq,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             alarm
);

    localparam int RUN_W = $clog2(RUN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q;
    logic               f_q, f_d;
    logic [WIDTH-2:0]   pair_q, pair_d;
    logic               hit;

    // Per-pair XNOR of the incoming sample and its mode-selected reduction.
    always_comb begin
        pair_d = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            pair_d[i] = ~(in_data[i+1] ^ in_data[i]);
        end
        f_d = mode ? (&pair_d) : (|pair_d);
        hit = in_valid & f_d;
    end

    // Run FSM next state; clr wins over any sample, idle cycles leave the run untouched.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (clr) begin
            state_d = IDLE;
            run_d   = '0;
        end else if (in_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (hit) begin
                        run_d   = RUN_W'(1);
                        state_d = (RUN_LEN == 1) ? ALARM : RUN;
                    end
                end
                RUN: begin
                    if (hit) begin
                        run_d = run_q + RUN_W'(1);
                        if ((run_q + RUN_W'(1)) == RUN_W'(RUN_LEN)) begin
                            state_d = ALARM;
                        end
                    end else begin
                        run_d   = '0;
                        state_d = IDLE;
                    end
                end
                ALARM: begin
                    state_d = ALARM;
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    // Saturating hit counter; clr discards any hit in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Run tracking and hit counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
        end
    end

    // Result registers: out_valid follows in_valid, f/pair_eq load only on accepted samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            f_q         <= 1'b0;
            pair_q      <= '0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                f_q    <= f_d;
                pair_q <= pair_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign f         = f_q;
    assign pair_eq   = pair_q;
    assign hit_cnt   = cnt_q;
    assign alarm     = (state_q == ALARM);

endmodule

// File: tb/tb_adj_eq_monitor.sv
// Purpose: directed self-checking bench for adj_eq_monitor (default counter and a 2-bit counter instance).
// Latency: checks are sampled 1 time unit after the accepting rising edge.
// Backpressure: not applicable; stimulus is applied on falling edges.
module tb_adj_eq_monitor;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       mode;
    logic       clr;

    logic       a_out_valid, a_f, a_alarm;
    logic [2:0] a_pair_eq;
    logic [7:0] a_hit_cnt;

    logic       b_out_valid, b_f, b_alarm;
    logic [2:0] b_pair_eq;
    logic [1:0] b_hit_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    adj_eq_monitor #(.WIDTH(4), .RUN_LEN(3), .CNT_W(8)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mode      (mode),
        .clr       (clr),
        .out_valid (a_out_valid),
        .f         (a_f),
        .pair_eq   (a_pair_eq),
        .hit_cnt   (a_hit_cnt),
        .alarm     (a_alarm)
    );

    adj_eq_monitor #(.WIDTH(4), .RUN_LEN(3), .CNT_W(2)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mode      (mode),
        .clr       (clr),
        .out_valid (b_out_valid),
        .f         (b_f),
        .pair_eq   (b_pair_eq),
        .hit_cnt   (b_hit_cnt),
        .alarm     (b_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then settle just past the rising edge.
    task automatic step(input logic v, input logic [3:0] d, input logic m, input logic c);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        mode     = m;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'b0000;
        mode     = 1'b0;
        clr      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_f",         32'(a_f),         32'd0);
        chk("rst_pair_eq",   32'(a_pair_eq),   32'd0);
        chk("rst_hit_cnt",   32'(a_hit_cnt),   32'd0);
        chk("rst_alarm",     32'(a_alarm),     32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Test 1: OR reduction
        step(1'b1, 4'b0101, 1'b0, 1'b0);
        chk("t1_s0_valid", 32'(a_out_valid), 32'd1);
        chk("t1_s0_pair",  32'(a_pair_eq),   32'b000);
        chk("t1_s0_f",     32'(a_f),         32'd0);
        step(1'b1, 4'b0011, 1'b0, 1'b0);
        chk("t1_s1_pair",  32'(a_pair_eq),   32'b101);
        chk("t1_s1_f",     32'(a_f),         32'd1);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        chk("t1_s2_pair",  32'(a_pair_eq),   32'b111);
        chk("t1_s2_f",     32'(a_f),         32'd1);
        chk("t1_hit_cnt",  32'(a_hit_cnt),   32'd2);
        step(1'b0, 4'b0000, 1'b0, 1'b1);
        chk("t1_idle_valid", 32'(a_out_valid), 32'd0);
        chk("t1_clr_cnt",    32'(a_hit_cnt),   32'd0);

        // Test 2: AND reduction
        step(1'b1, 4'b0101, 1'b1, 1'b0);
        chk("t2_s0_f", 32'(a_f), 32'd0);
        step(1'b1, 4'b0011, 1'b1, 1'b0);
        chk("t2_s1_f", 32'(a_f), 32'd0);
        step(1'b1, 4'b1111, 1'b1, 1'b0);
        chk("t2_s2_f",   32'(a_f),       32'd1);
        chk("t2_hit_cnt", 32'(a_hit_cnt), 32'd1);
        chk("t2_alarm",  32'(a_alarm),   32'd0);
        step(1'b0, 4'b0000, 1'b0, 1'b1);

        // Test 3: idle cycle inside a run does not break it
        step(1'b1, 4'b0011, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        chk("t3_pre_alarm", 32'(a_alarm), 32'd0);
        step(1'b0, 4'b0101, 1'b0, 1'b0);
        chk("t3_idle_valid", 32'(a_out_valid), 32'd0);
        chk("t3_idle_f_hold", 32'(a_f),        32'd1);
        chk("t3_idle_pair_hold", 32'(a_pair_eq), 32'b111);
        chk("t3_idle_alarm", 32'(a_alarm),     32'd0);
        step(1'b1, 4'b1100, 1'b0, 1'b0);
        chk("t3_alarm_valid", 32'(a_out_valid), 32'd1);
        chk("t3_alarm_pair",  32'(a_pair_eq),   32'b101);
        chk("t3_alarm",       32'(a_alarm),     32'd1);
        step(1'b1, 4'b0101, 1'b0, 1'b0);
        chk("t3_miss_f",     32'(a_f),       32'd0);
        chk("t3_sticky",     32'(a_alarm),   32'd1);
        chk("t3_hit_cnt",    32'(a_hit_cnt), 32'd3);
        step(1'b0, 4'b0000, 1'b0, 1'b1);
        chk("t3_clr_alarm",  32'(a_alarm),   32'd0);
        chk("t3_clr_cnt",    32'(a_hit_cnt), 32'd0);

        // Test 4: miss breaks the run
        step(1'b1, 4'b0011, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        step(1'b1, 4'b0101, 1'b0, 1'b0);
        chk("t4_after_miss", 32'(a_alarm), 32'd0);
        step(1'b1, 4'b0011, 1'b0, 1'b0);
        chk("t4_alarm",   32'(a_alarm),   32'd0);
        chk("t4_hit_cnt", 32'(a_hit_cnt), 32'd3);
        step(1'b0, 4'b0000, 1'b0, 1'b1);
        chk("t4_clr_cnt", 32'(a_hit_cnt), 32'd0);
        chk("t4_clr_cnt_b", 32'(b_hit_cnt), 32'd0);

        // Test 5: 2-bit counter saturation, clr beats a coincident hit
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        chk("t5_cnt1", 32'(b_hit_cnt), 32'd1);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        chk("t5_cnt2", 32'(b_hit_cnt), 32'd2);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        chk("t5_cnt3", 32'(b_hit_cnt), 32'd3);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        chk("t5_cnt4", 32'(b_hit_cnt), 32'd3);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        chk("t5_cnt5", 32'(b_hit_cnt), 32'd3);
        chk("t5_cnt5_a", 32'(a_hit_cnt), 32'd5);
        step(1'b1, 4'b1111, 1'b0, 1'b1);
        chk("t5_clr_cnt",   32'(b_hit_cnt),   32'd0);
        chk("t5_clr_valid", 32'(b_out_valid), 32'd1);
        chk("t5_clr_f",     32'(b_f),         32'd1);
        chk("t5_clr_alarm", 32'(b_alarm),     32'd0);
        chk("t5_clr_alarm_a", 32'(a_alarm),   32'd0);
        // The clr-cycle hit must not have started a run: two more hits stay below RUN_LEN.
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        chk("t5_no_run_from_clr", 32'(a_alarm), 32'd0);
        step(1'b0, 4'b0000, 1'b0, 1'b1);

        // Test 6: asynchronous reset mid-run
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        step(1'b1, 4'b0011, 1'b0, 1'b0);
        chk("t6_run2_cnt", 32'(a_hit_cnt), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_arst_valid", 32'(a_out_valid), 32'd0);
        chk("t6_arst_f",     32'(a_f),         32'd0);
        chk("t6_arst_pair",  32'(a_pair_eq),   32'd0);
        chk("t6_arst_cnt",   32'(a_hit_cnt),   32'd0);
        chk("t6_arst_alarm", 32'(a_alarm),     32'd0);
        @(posedge clk);
        #1;
        chk("t6_hold_valid", 32'(a_out_valid), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        chk("t6_two_hits_alarm", 32'(a_alarm),   32'd0);
        chk("t6_two_hits_cnt",   32'(a_hit_cnt), 32'd2);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        chk("t6_third_alarm",    32'(a_alarm),   32'd1);
        chk("t6_third_cnt",      32'(a_hit_cnt), 32'd3);
        step(1'b0, 4'b0000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adj_eq_monitor.md
Name: adj_eq_monitor

Overview:
Registered, parametrised successor to the lab 3-input adjacent-equality combinational function. It accepts a WIDTH-bit sample per valid cycle and computes the XNOR of every adjacent bit pair. It reduces the pairs to a single flag f, either OR-reduced (any adjacent pair equal) or AND-reduced (all adjacent pairs equal). It also counts hits and raises a sticky alarm after RUN_LEN consecutive hits. It sits between a sample source (switches or a test stimulus block) and the status/LED logic.

Parameters:
WIDTH, 4, input sample width; legal range >= 2.
RUN_LEN, 3, consecutive accepted hits needed to raise alarm; legal range >= 1.
CNT_W, 8, width of the saturating hit counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  sample qualifier; the sample is accepted on any rising clk edge where in_valid=1.
in_data  input  WIDTH  sample bits.
mode  input  1  0 = OR reduction; 1 = AND reduction; sampled together with in_data.
clr  input  1  synchronous clear of hit_cnt, run tracking and alarm.
out_valid  output  1  one-cycle pulse; f and pair_eq are valid for the accepted sample.
f  output  1  registered reduction result.
pair_eq  output  WIDTH-1  registered per-pair equality; bit i = ~(in_data[i+1] ^ in_data[i]).
hit_cnt  output  CNT_W  saturating count of accepted samples with f=1.
alarm  output  1  sticky flag for RUN_LEN consecutive hits.

Behaviour:
- Reset (async, rst=1): out_valid=0, f=0, pair_eq=0, hit_cnt=0, alarm=0, run counter=0, FSM=IDLE. Outputs hold these values while rst=1. No sample is accepted while rst=1.
- Latency: 1 cycle. A sample accepted at edge N drives out_valid/f/pair_eq after edge N. It updates hit_cnt and alarm at the same edge N.
- out_valid equals in_valid registered; it is 0 on cycles with no accepted sample.
- f and pair_eq hold their last values while out_valid=0.
- f = mode ? &pair_eq : |pair_eq. Both are computed from the same in_data and mode as the accepted sample.
- hit_cnt increments by 1 per accepted hit (f=1). It saturates at 2^CNT_W-1 and never wraps.
- Run FSM; it advances only on accepted samples. Idle cycles (in_valid=0) neither extend nor break a run.
  - IDLE: hit -> run=1. If RUN_LEN=1, go to ALARM; otherwise go to RUN. Miss -> stay in IDLE.
  - RUN: hit -> run+1. If run+1 = RUN_LEN, go to ALARM. Miss -> run=0, IDLE.
  - ALARM: alarm=1. Remains in ALARM on hits and misses until clr or rst. hit_cnt keeps counting in ALARM.
- alarm rises at the same edge that registers the RUN_LEN-th consecutive hit, so it coincides with that sample's out_valid.
- clr=1 at edge:
  - hit_cnt=0, run=0, FSM=IDLE, alarm=0.
  - clr has priority over counting. A sample accepted in the same cycle still produces out_valid/f/pair_eq but is not counted and does not start a run.
- Reset mid-run or mid-alarm clears everything immediately, without waiting for clk. The first accepted sample after rst deasserts starts a fresh run.
- mode may change every sample. A run may span samples taken in different modes; hits are judged per sample.
- Width rules:
  - the run counter is clog2(RUN_LEN+1) bits wide;
  - pair_eq has WIDTH-1 bits;
  - no arithmetic on in_data.

Test Plan:
1. WIDTH=4, mode=0: in_data=4'b0101, then 4'b0011, then 4'b1111.
   - 4'b0101 -> pair_eq=3'b000, f=0.
   - 4'b0011 -> pair_eq=3'b101, f=1.
   - 4'b1111 -> pair_eq=3'b111, f=1.
   - Final hit_cnt=2. Each out_valid comes exactly 1 cycle after its in_valid.
2. mode=1, same three samples -> f=0, 0, 1; hit_cnt=1; alarm=0.
3. RUN_LEN=3, mode=0: samples 0011, 1111, idle cycle, 1100.
   - alarm=1 together with the out_valid of 1100 (the idle cycle does not break the run).
   - Then 0101 (miss) -> alarm stays 1; hit_cnt=3.
4. RUN_LEN=3: 0011, 1111, 0101, 0011 -> alarm stays 0, because the run resets on 0101. clr pulse -> hit_cnt=0.
5. CNT_W=2: five hits (1111) -> hit_cnt sequence 1, 2, 3, 3, 3. clr asserted together with a sixth hit -> hit_cnt=0, out_valid=1, f=1, alarm=0.
6. Async reset: assert rst mid-run (run=2) between clock edges.
   - All outputs reach 0 before the next edge.
   - After release, two hits do not raise alarm; a third hit does.
